// File: rtl/mem_defs_pkg.sv
// Shared opcode, address window and FSM encodings
// for the CPU-side SRAM request master.
package mem_defs_pkg;

   localparam logic [5:0] OP_LB = 6'b100000;
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SW = 6'b101011;

   localparam logic [31:0] BASE_LO = 32'h8000_0000;
   localparam logic [31:0] EXT_HI  = 32'h807F_FFFF;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE     = 3'd0;
   localparam state_t S_FETCH    = 3'd1;
   localparam state_t S_RD       = 3'd2;
   localparam state_t S_WR_SETUP = 3'd3;
   localparam state_t S_WR_PULSE = 3'd4;
   localparam state_t S_WR_HOLD  = 3'd5;
   localparam state_t S_DONE     = 3'd6;

   function automatic logic op_ok(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LW) ||
             (op == OP_SB) || (op == OP_SW);
   endfunction

   function automatic logic addr_ok(input logic [31:0] a);
      return (a >= BASE_LO) && (a <= EXT_HI);
   endfunction

endpackage

// File: rtl/ram_req_master_if.sv
// Request/response bundle between the request master
// and the SRAM controller.
interface ram_req_master_if;

   logic        inst_ce;
   logic [31:0] inst_addr;
   logic        mem_ce;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_i;
   logic [5:0]  Op;
   logic        stall;
   logic [31:0] inst;
   logic [31:0] mem_data_o;

   modport master (
      output inst_ce, inst_addr,
      output mem_ce, mem_we, mem_addr,
      output mem_data_i, Op, stall,
      input  inst, mem_data_o
   );

   modport slave (
      input  inst_ce, inst_addr,
      input  mem_ce, mem_we, mem_addr,
      input  mem_data_i, Op, stall,
      output inst, mem_data_o
   );

endinterface

// File: rtl/ram_req_master.sv
// Turns pipeline fetch/load/store requests into timed
// SRAM strobes; data access wins over fetch.
module ram_req_master #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [31:0]      if_addr,
   output logic [31:0]      if_inst,
   output logic             if_valid,
   input  logic             ex_req,
   input  logic             ex_we,
   input  logic [5:0]       ex_op,
   input  logic [31:0]      ex_addr,
   input  logic [31:0]      ex_wdata,
   output logic [31:0]      ex_rdata,
   output logic             ex_done,
   output logic             stall_o,
   ram_req_master_if.master ram
);

   import mem_defs_pkg::*;

   localparam int CW = $clog2(WAIT_CYCLES + 2);
   localparam logic [CW-1:0] CNT_RD = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_WR = CW'(WAIT_CYCLES - 1);

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic          is_ex;
   logic          ex_sel;
   logic          ex_ok;
   logic          last_rd;
   logic          last_wr;

   assign ex_ok   = op_ok(ex_op) & addr_ok(ex_addr);
   assign last_rd = (cnt == CNT_RD);
   assign last_wr = (cnt == CNT_WR);
   assign ex_sel  = (state == S_IDLE) ? ex_req : is_ex;

   assign stall_o = (ex_req & ~ex_done) | (if_req & ~if_valid);

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: begin
            unique case (1'b1)
               ex_req & ~ex_ok:         state_n = S_DONE;
               ex_req & ex_ok & ex_we:  state_n = S_WR_SETUP;
               ex_req & ex_ok & ~ex_we: state_n = S_RD;
               ~ex_req & if_req:        state_n = S_FETCH;
               default:                 state_n = S_IDLE;
            endcase
         end
         S_FETCH:    if (last_rd) state_n = S_DONE;
         S_RD:       if (last_rd) state_n = S_DONE;
         S_WR_SETUP: state_n = S_WR_PULSE;
         S_WR_PULSE: if (last_wr) state_n = S_WR_HOLD;
         S_WR_HOLD:  state_n = S_DONE;
         S_DONE:     state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   // Ram-side strobes are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         is_ex          <= 1'b0;
         if_inst        <= '0;
         if_valid       <= 1'b0;
         ex_rdata       <= '0;
         ex_done        <= 1'b0;
         ram.inst_ce    <= 1'b0;
         ram.inst_addr  <= '0;
         ram.mem_ce     <= 1'b0;
         ram.mem_we     <= 1'b0;
         ram.mem_addr   <= '0;
         ram.mem_data_i <= '0;
         ram.Op         <= '0;
         ram.stall      <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= (state_n != state) ? '0 : cnt + 1'b1;

         ram.inst_ce <= (state_n == S_FETCH);
         ram.mem_ce  <= (state_n == S_RD) ||
                        (state_n == S_WR_PULSE);
         ram.mem_we  <= (state_n == S_WR_PULSE);
         ram.stall   <= (state_n != S_IDLE) &&
                        (state_n != S_FETCH);
         if_valid    <= (state_n == S_DONE) & ~ex_sel;
         ex_done     <= (state_n == S_DONE) & ex_sel;

         if (state == S_IDLE) begin
            if (ex_req) begin
               is_ex <= 1'b1;
               if (ex_ok) begin
                  ram.mem_addr   <= ex_addr;
                  ram.Op         <= ex_op;
                  ram.mem_data_i <= ex_wdata;
               end else begin
                  ex_rdata <= '0;
               end
            end else if (if_req) begin
               is_ex         <= 1'b0;
               ram.inst_addr <= if_addr;
            end
         end

         if ((state == S_FETCH) && last_rd)
            if_inst <= ram.inst;
         if ((state == S_RD) && last_rd)
            ex_rdata <= ram.mem_data_o;
      end
   end

endmodule

// File: tb/tb_ram_req_master.sv
// Scoreboarded bench for ram_req_master with a small
// behavioural ram/SRAM model behind the interface.
module tb_ram_req_master;

   import mem_defs_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        if_valid;
   logic        ex_req;
   logic        ex_we;
   logic [5:0]  ex_op;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [31:0] ex_rdata;
   logic        ex_done;
   logic        stall_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic overlap = 1'b0;

   ram_req_master_if ifc();

   ram_req_master #(.WAIT_CYCLES(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_inst  (if_inst),
      .if_valid (if_valid),
      .ex_req   (ex_req),
      .ex_we    (ex_we),
      .ex_op    (ex_op),
      .ex_addr  (ex_addr),
      .ex_wdata (ex_wdata),
      .ex_rdata (ex_rdata),
      .ex_done  (ex_done),
      .stall_o  (stall_o),
      .ram      (ifc)
   );

   always #5 clk = ~clk;

   logic [31:0] sram [32];
   logic [31:0] rw;
   logic [7:0]  rb;

   function automatic logic [4:0] widx(input logic [31:0] a);
      return {a[22], a[5:2]};
   endfunction

   // Little-endian lanes; LB returns the sign-extended byte.
   always_comb begin
      ifc.inst       = sram[widx(ifc.inst_addr)];
      rw             = sram[widx(ifc.mem_addr)];
      rb             = rw[{ifc.mem_addr[1:0], 3'b000} +: 8];
      ifc.mem_data_o = (ifc.Op == OP_LB) ? {{24{rb[7]}}, rb} : rw;
   end

   always @(posedge clk) begin
      if (rst) begin
         sram[0]  <= 32'h1122_3344;
         sram[4]  <= 32'h2402_0005;
         sram[17] <= 32'h0000_0000;
      end else if (ifc.mem_ce && ifc.mem_we) begin
         if (ifc.Op == OP_SB)
            sram[widx(ifc.mem_addr)][{ifc.mem_addr[1:0], 3'b000} +: 8]
               <= ifc.mem_data_i[7:0];
         else
            sram[widx(ifc.mem_addr)] <= ifc.mem_data_i;
      end
   end

   always @(posedge clk)
      if (ifc.inst_ce && ifc.mem_ce) overlap <= 1'b1;

   task automatic run_ex(
      input  logic        we,
      input  logic [5:0]  op,
      input  logic [31:0] addr,
      input  logic [31:0] wd,
      output int          done_cyc,
      output logic [15:0] ce_m,
      output logic [15:0] we_m,
      output logic [31:0] rd
   );
      done_cyc = -1;
      ce_m = '0;
      we_m = '0;
      rd = '0;
      ex_we = we;
      ex_op = op;
      ex_addr = addr;
      ex_wdata = wd;
      ex_req = 1'b1;
      for (int k = 1; k < 16 && done_cyc < 0; k++) begin
         @(posedge clk); #1;
         ce_m[k] = ifc.mem_ce;
         we_m[k] = ifc.mem_we;
         if (ex_done) begin
            done_cyc = k;
            rd = ex_rdata;
         end
      end
      ex_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      if_req = 1'b0;
      ex_req = 1'b0;
      if_addr = '0;
      ex_we = 1'b0;
      ex_op = '0;
      ex_addr = '0;
      ex_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({if_valid, ex_done, stall_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_pulses got %b want 000",
                  {if_valid, ex_done, stall_o});
      end
      checks++;
      if ({ifc.inst_ce, ifc.mem_ce, ifc.mem_we, ifc.stall} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes got %b want 0000",
                  {ifc.inst_ce, ifc.mem_ce, ifc.mem_we, ifc.stall});
      end
      checks++;
      if ({if_inst, ex_rdata} !== 64'd0) begin
         errors++;
         $display("FAIL reset_data got %h %h want 0 0", if_inst, ex_rdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fetch;
      int          vcyc;
      logic [15:0] ice;
      logic        st1;
      logic [31:0] got;
      logic [31:0] want;
      vcyc = -1;
      ice = '0;
      st1 = 1'b0;
      got = '0;
      exp_q.push_back(32'h2402_0005);
      if_addr = 32'h8000_0010;
      if_req = 1'b1;
      for (int k = 1; k < 16 && vcyc < 0; k++) begin
         @(posedge clk); #1;
         ice[k] = ifc.inst_ce;
         if (k == 1) begin
            st1 = stall_o;
            if_addr = 32'h8000_0000;
         end
         if (if_valid) begin
            vcyc = k;
            got = if_inst;
         end
      end
      if_req = 1'b0;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if (vcyc !== 3) begin
         errors++;
         $display("FAIL fetch_latency got %0d want 3", vcyc);
      end
      checks++;
      if (ice !== 16'h0006) begin
         errors++;
         $display("FAIL fetch_inst_ce got %h want 0006", ice);
      end
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL fetch_inst got %h want %h", got, want);
      end
      checks++;
      if (st1 !== 1'b1) begin
         errors++;
         $display("FAIL fetch_stall_o got %b want 1", st1);
      end
   endtask

   task automatic test_store_load;
      int          dc;
      logic [15:0] ce;
      logic [15:0] we;
      logic [31:0] rd;
      logic [31:0] want;
      run_ex(1'b1, OP_SW, 32'h8040_0004, 32'hDEAD_BEEF, dc, ce, we, rd);
      checks++;
      if (dc !== 4) begin
         errors++;
         $display("FAIL sw_latency got %0d want 4", dc);
      end
      checks++;
      if ({ce, we} !== {16'h0004, 16'h0004}) begin
         errors++;
         $display("FAIL sw_strobes got ce %h we %h want 0004 0004", ce, we);
      end
      exp_q.push_back(32'hDEAD_BEEF);
      run_ex(1'b0, OP_LW, 32'h8040_0004, 32'h0, dc, ce, we, rd);
      want = exp_q.pop_front();
      checks++;
      if (dc !== 3) begin
         errors++;
         $display("FAIL lw_latency got %0d want 3", dc);
      end
      checks++;
      if (rd !== want) begin
         errors++;
         $display("FAIL lw_data got %h want %h", rd, want);
      end
      checks++;
      if ({ce, we} !== {16'h0006, 16'h0000}) begin
         errors++;
         $display("FAIL lw_strobes got ce %h we %h want 0006 0000", ce, we);
      end
   endtask

   task automatic test_byte;
      int          dc;
      logic [15:0] ce;
      logic [15:0] we;
      logic [31:0] rd;
      logic [31:0] want;
      run_ex(1'b1, OP_SB, 32'h8000_0003, 32'h0000_0080, dc, ce, we, rd);
      exp_q.push_back(32'hFFFF_FF80);
      run_ex(1'b0, OP_LB, 32'h8000_0003, 32'h0, dc, ce, we, rd);
      want = exp_q.pop_front();
      checks++;
      if (rd !== want) begin
         errors++;
         $display("FAIL lb_data got %h want %h", rd, want);
      end
      exp_q.push_back(32'h8022_3344);
      run_ex(1'b0, OP_LW, 32'h8000_0000, 32'h0, dc, ce, we, rd);
      want = exp_q.pop_front();
      checks++;
      if (rd !== want) begin
         errors++;
         $display("FAIL sb_neighbours got %h want %h", rd, want);
      end
   endtask

   task automatic test_priority;
      int          dcyc;
      int          vcyc;
      int          icyc;
      logic [31:0] gd;
      logic [31:0] gi;
      logic [31:0] wd;
      logic [31:0] wi;
      dcyc = -1;
      vcyc = -1;
      icyc = -1;
      gd = '0;
      gi = '0;
      exp_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(32'h2402_0005);
      if_addr = 32'h8000_0010;
      ex_we = 1'b0;
      ex_op = OP_LW;
      ex_addr = 32'h8040_0004;
      if_req = 1'b1;
      ex_req = 1'b1;
      for (int k = 1; k < 20 && vcyc < 0; k++) begin
         @(posedge clk); #1;
         if (ifc.inst_ce && icyc < 0) icyc = k;
         if (ex_done) begin
            dcyc = k;
            gd = ex_rdata;
            ex_req = 1'b0;
         end
         if (if_valid) begin
            vcyc = k;
            gi = if_inst;
            if_req = 1'b0;
         end
      end
      if_req = 1'b0;
      ex_req = 1'b0;
      @(posedge clk); #1;
      wd = exp_q.pop_front();
      wi = exp_q.pop_front();
      checks++;
      if ({dcyc, icyc, vcyc} !== {32'sd3, 32'sd5, 32'sd7}) begin
         errors++;
         $display("FAIL prio_order got done %0d ice %0d valid %0d want 3 5 7",
                  dcyc, icyc, vcyc);
      end
      checks++;
      if ({gd, gi} !== {wd, wi}) begin
         errors++;
         $display("FAIL prio_data got %h %h want %h %h", gd, gi, wd, wi);
      end
   endtask

   task automatic test_bypass;
      int          dc;
      logic [15:0] ce;
      logic [15:0] we;
      logic [31:0] rd;
      logic [31:0] want;
      exp_q.push_back(32'h0);
      run_ex(1'b0, OP_LW, 32'h9000_0000, 32'h0, dc, ce, we, rd);
      want = exp_q.pop_front();
      checks++;
      if ({dc, rd, ce} !== {32'sd1, want, 16'h0000}) begin
         errors++;
         $display("FAIL bypass_addr got cyc %0d data %h ce %h want 1 %h 0000",
                  dc, rd, ce, want);
      end
      run_ex(1'b0, OP_LW, 32'h8040_0004, 32'h0, dc, ce, we, rd);
      exp_q.push_back(32'h0);
      run_ex(1'b1, 6'b001000, 32'h8040_0004, 32'h1234_5678, dc, ce, we, rd);
      want = exp_q.pop_front();
      checks++;
      if ({dc, rd, ce, we} !== {32'sd1, want, 16'h0000, 16'h0000}) begin
         errors++;
         $display("FAIL bypass_op got cyc %0d data %h ce %h we %h want 1 %h 0 0",
                  dc, rd, ce, we, want);
      end
   endtask

   task automatic test_reset_mid_write;
      logic pulse_seen;
      logic done_seen;
      pulse_seen = 1'b0;
      done_seen = 1'b0;
      ex_we = 1'b1;
      ex_op = OP_SW;
      ex_addr = 32'h8040_0008;
      ex_wdata = 32'hCAFE_F00D;
      ex_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      pulse_seen = ifc.mem_ce & ifc.mem_we;
      rst = 1'b1;
      ex_req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({pulse_seen, ifc.mem_ce, ifc.mem_we, ifc.stall} !== 4'b1000) begin
         errors++;
         $display("FAIL rst_abort got pulse/ce/we/stall %b want 1000",
                  {pulse_seen, ifc.mem_ce, ifc.mem_we, ifc.stall});
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (ex_done || if_valid) done_seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (done_seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_done got %b want 0", done_seen);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store_load();
      test_byte();
      test_priority();
      test_bypass();
      test_reset_mid_write();
      checks++;
      if (overlap !== 1'b0) begin
         errors++;
         $display("FAIL ce_exclusive got overlap %b want 0", overlap);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
